// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared state encoding, mode codes and default widths for the serial bus ports
//
// Purpose: common definitions used by the master port (and its slave-port counterpart).
// Contents: bus_state_e transfer state encoding, MODE_READ/MODE_WRITE, default
// address/data widths, and a small max helper for sizing shared registers.
package bus_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQ      = 3'd1,
        ADDR     = 3'd2,
        WAIT_ACK = 3'd3,
        WDATA    = 3'd4,
        RDATA    = 3'd5
    } bus_state_e;

    localparam logic MODE_READ  = 1'b0;
    localparam logic MODE_WRITE = 1'b1;

    localparam int BUS_ADDR_WIDTH = 14;
    localparam int BUS_DATA_WIDTH = 8;

    function automatic int max_width(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/serial_shifter.sv
// rtl/serial_shifter.sv - bit-indexed PISO/SIPO register with load and bit counter
//
// Purpose: holds one serial word. Bits are read out (and written in) LSB first at the
// position given by the internal bit counter, so the same register serves both the
// outgoing address/write data and the incoming read data.
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   clr            clear the bit counter (register contents untouched)
//   load           load load_data and clear the counter (wins over everything else)
//   load_data      parallel word to load
//   shift_out_en   advance the counter past the bit currently on sout
//   shift_in_en    write sin at the counter position and advance
//   sin            serial input bit
//   sout           bit at the current counter position
//   cnt            current bit counter
//   data_next      register value after this edge (includes a bit being shifted in now)
module serial_shifter #(
    parameter int WIDTH = 14,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_out_en,
    input  logic             shift_in_en,
    input  logic             sin,
    output logic             sout,
    output logic [CNT_W-1:0] cnt,
    output logic [WIDTH-1:0] data_next
);

    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shifted;
    logic [WIDTH-1:0] bit_mask;

    always_comb begin
        bit_mask = WIDTH'(1) << cnt_q;
        shifted  = sreg_q >> cnt_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;

        // The incoming bit is written even when the counter is cleared on the same
        // edge, so the final bit of a word lands together with the state change.
        if (load) begin
            sreg_d = load_data;
        end else if (shift_in_en) begin
            sreg_d = (sreg_q & ~bit_mask) | (WIDTH'(sin) << cnt_q);
        end

        if (load || clr) begin
            cnt_d = '0;
        end else if (shift_out_en || shift_in_en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            sreg_q <= '0;
            cnt_q  <= '0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
        end
    end

    assign sout      = shifted[0];
    assign cnt       = cnt_q;
    assign data_next = sreg_d;

endmodule

// File: rtl/master_port.sv
// rtl/master_port.sv - bus-side master port: request, grant, serial address/data, ack timeout
//
// Purpose: takes one parallel read/write request from the local device, requests the
// serial bus, shifts the address (and write data) out LSB first while granted, and
// collects serial read data. Aborts on ack timeout or loss of grant.
// Ports:
//   clk, rstn                     clock, synchronous active-low reset
//   dvalid/dmode/daddr/dwdata     device request (accepted only while dready=1)
//   dready                        high in IDLE
//   drdata                        last completed read data
//   ddone/dfail                   one-cycle completion / abort pulses
//   breq/bgrant                   arbiter request / grant
//   mwdata/mvalid/mmode           serial address/data bit, its valid, latched mode
//   ack                           slave acknowledge after the address phase
//   mrdata/svalid                 serial read data bit from the slave and its valid
module master_port
    import bus_pkg::*;
#(
    parameter int ADDR_WIDTH  = BUS_ADDR_WIDTH,
    parameter int DATA_WIDTH  = BUS_DATA_WIDTH,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  dvalid,
    input  logic                  dmode,
    input  logic [ADDR_WIDTH-1:0] daddr,
    input  logic [DATA_WIDTH-1:0] dwdata,
    output logic                  dready,
    output logic [DATA_WIDTH-1:0] drdata,
    output logic                  ddone,
    output logic                  dfail,
    output logic                  breq,
    input  logic                  bgrant,
    output logic                  mwdata,
    output logic                  mvalid,
    output logic                  mmode,
    input  logic                  ack,
    input  logic                  mrdata,
    input  logic                  svalid
);

    localparam int SH_W  = max_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int CNT_W = $clog2(SH_W + 1);
    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_WIDTH - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_WIDTH - 1);
    localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] TMR_MAX   = TMR_W'(ACK_TIMEOUT);

    bus_state_e            state_q, state_d;
    logic                  settled_q, settled_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  mmode_q, mmode_d;
    logic [DATA_WIDTH-1:0] drdata_q, drdata_d;
    logic                  ddone_q, ddone_d;
    logic                  dfail_q, dfail_d;
    logic                  dready_q;
    logic                  breq_q;
    logic                  mvalid_q;

    logic                  sh_clr;
    logic                  sh_load;
    logic [SH_W-1:0]       sh_load_data;
    logic                  sh_out_en;
    logic                  sh_in_en;
    logic                  sh_sout;
    logic [CNT_W-1:0]      sh_cnt;
    logic [SH_W-1:0]       sh_data_next;
    logic                  unused_rx;

    serial_shifter #(
        .WIDTH (SH_W),
        .CNT_W (CNT_W)
    ) u_shifter (
        .clk          (clk),
        .rstn         (rstn),
        .clr          (sh_clr),
        .load         (sh_load),
        .load_data    (sh_load_data),
        .shift_out_en (sh_out_en),
        .shift_in_en  (sh_in_en),
        .sin          (mrdata),
        .sout         (sh_sout),
        .cnt          (sh_cnt),
        .data_next    (sh_data_next)
    );

    always_comb begin
        state_d      = state_q;
        settled_d    = settled_q;
        timer_d      = timer_q;
        wdata_d      = wdata_q;
        mmode_d      = mmode_q;
        drdata_d     = drdata_q;
        ddone_d      = 1'b0;
        dfail_d      = 1'b0;
        sh_load      = 1'b0;
        sh_load_data = SH_W'(daddr);
        sh_out_en    = 1'b0;
        sh_in_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (dvalid) begin
                    state_d = REQ;
                    wdata_d = dwdata;
                    mmode_d = dmode;
                    sh_load = 1'b1;
                end
            end

            // The arbiter's grant is registered, so a grant seen in the first REQ
            // cycle may be left over from an earlier owner and is not trusted.
            REQ: begin
                if (settled_q && bgrant) begin
                    state_d = ADDR;
                end else begin
                    settled_d = 1'b1;
                end
            end

            ADDR: begin
                if (!bgrant) begin
                    state_d = IDLE;
                    dfail_d = 1'b1;
                end else begin
                    sh_out_en = 1'b1;
                    if (sh_cnt == ADDR_LAST) begin
                        state_d = WAIT_ACK;
                    end
                end
            end

            // Grant loss beats everything; an ack in the final timer cycle still wins.
            WAIT_ACK: begin
                if (!bgrant) begin
                    state_d = IDLE;
                    dfail_d = 1'b1;
                end else if (ack) begin
                    if (mmode_q == MODE_WRITE) begin
                        state_d      = WDATA;
                        sh_load      = 1'b1;
                        sh_load_data = SH_W'(wdata_q);
                    end else begin
                        state_d = RDATA;
                    end
                end else if (timer_q == TMR_LAST) begin
                    state_d = IDLE;
                    dfail_d = 1'b1;
                end else if (timer_q != TMR_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end

            WDATA: begin
                if (!bgrant) begin
                    state_d = IDLE;
                    dfail_d = 1'b1;
                end else begin
                    sh_out_en = 1'b1;
                    if (sh_cnt == DATA_LAST) begin
                        state_d = IDLE;
                        ddone_d = 1'b1;
                    end
                end
            end

            RDATA: begin
                if (!bgrant) begin
                    state_d = IDLE;
                    dfail_d = 1'b1;
                end else if (svalid) begin
                    sh_in_en = 1'b1;
                    if (sh_cnt == DATA_LAST) begin
                        state_d  = IDLE;
                        ddone_d  = 1'b1;
                        drdata_d = sh_data_next[DATA_WIDTH-1:0];
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d != state_q) begin
            timer_d   = '0;
            settled_d = 1'b0;
        end
        if (state_d == IDLE) begin
            mmode_d = 1'b0;
        end
    end

    assign sh_clr    = (state_d != state_q);
    assign unused_rx = ^sh_data_next;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= IDLE;
            settled_q <= 1'b0;
            timer_q   <= '0;
            wdata_q   <= '0;
            mmode_q   <= 1'b0;
            drdata_q  <= '0;
            ddone_q   <= 1'b0;
            dfail_q   <= 1'b0;
            dready_q  <= 1'b1;
            breq_q    <= 1'b0;
            mvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            settled_q <= settled_d;
            timer_q   <= timer_d;
            wdata_q   <= wdata_d;
            mmode_q   <= mmode_d;
            drdata_q  <= drdata_d;
            ddone_q   <= ddone_d;
            dfail_q   <= dfail_d;
            dready_q  <= (state_d == IDLE);
            breq_q    <= (state_d != IDLE);
            mvalid_q  <= (state_d == ADDR) || (state_d == WDATA);
        end
    end

    assign dready = dready_q;
    assign drdata = drdata_q;
    assign ddone  = ddone_q;
    assign dfail  = dfail_q;
    assign breq   = breq_q;
    assign mvalid = mvalid_q;
    assign mmode  = mmode_q;
    // Both operands are flops; the bit shown is the one at the current counter.
    assign mwdata = mvalid_q & sh_sout;

endmodule

// File: tb/tb_master_port.sv
// tb/tb_master_port.sv - directed and randomized checks of master_port against a cycle-count model
module tb_master_port;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 8;
    localparam int ACK_TO = 16;

    logic              clk = 1'b0;
    logic              rstn;
    logic              dvalid;
    logic              dmode;
    logic [ADDR_W-1:0] daddr;
    logic [DATA_W-1:0] dwdata;
    logic              dready;
    logic [DATA_W-1:0] drdata;
    logic              ddone;
    logic              dfail;
    logic              breq;
    logic              bgrant;
    logic              mwdata;
    logic              mvalid;
    logic              mmode;
    logic              ack;
    logic              mrdata;
    logic              svalid;

    int                n_run  = 0;
    int                n_fail = 0;
    logic [DATA_W-1:0] exp_drdata = '0;

    master_port #(
        .ADDR_WIDTH  (ADDR_W),
        .DATA_WIDTH  (DATA_W),
        .ACK_TIMEOUT (ACK_TO)
    ) dut (
        .clk    (clk),
        .rstn   (rstn),
        .dvalid (dvalid),
        .dmode  (dmode),
        .daddr  (daddr),
        .dwdata (dwdata),
        .dready (dready),
        .drdata (drdata),
        .ddone  (ddone),
        .dfail  (dfail),
        .breq   (breq),
        .bgrant (bgrant),
        .mwdata (mwdata),
        .mvalid (mvalid),
        .mmode  (mmode),
        .ack    (ack),
        .mrdata (mrdata),
        .svalid (svalid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transfer. g: cycles after the first breq cycle before bgrant rises (-1 = already high);
    // k: WAIT_ACK cycles before ack (>= ACK_TO means never); gap: idle cycles before each read bit;
    // drop: data-phase cycle at which bgrant falls (-1 = never); hold_dv keeps dvalid high.
    task automatic xfer(input string name, input logic mode, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input logic [DATA_W-1:0] rd,
                        input int g, input int k, input int gap, input int drop, input bit hold_dv);
        int a0, w0, p0, exp_end, t, end_t, na, first_mv, w_obs, ack_t, rel, breq_bad, mmode_bad;
        bit exp_ok, ended;
        logic [ADDR_W-1:0] bits_a;
        logic [DATA_W-1:0] bits_d;

        // Reference timeline from dvalid at cycle 0.
        a0 = (((1 + g) > 2) ? (1 + g) : 2) + 1;
        w0 = a0 + ADDR_W;
        p0 = w0 + k + 1;
        if (k >= ACK_TO) begin
            exp_ok  = 1'b0;
            exp_end = w0 + ACK_TO;
        end else if (drop >= 0) begin
            exp_ok  = 1'b0;
            exp_end = p0 + drop + 1;
        end else if (mode) begin
            exp_ok  = 1'b1;
            exp_end = p0 + DATA_W;
        end else begin
            exp_ok  = 1'b1;
            exp_end = p0 + DATA_W * (gap + 1);
        end

        dvalid = 1'b1; dmode = mode; daddr = addr; dwdata = wd;
        bgrant = (g < 0); ack = 1'b0; svalid = 1'b0; mrdata = 1'b0;
        t = 0; end_t = -1; na = 0; first_mv = -1; w_obs = -1; ack_t = -1;
        breq_bad = 0; mmode_bad = 0; ended = 1'b0; bits_a = '0; bits_d = '0;

        while (!ended && t < 400) begin
            tick();
            t++;
            if (ddone || dfail) begin
                ended = 1'b1;
                end_t = t;
            end
            if (mvalid) begin
                if (first_mv < 0) first_mv = t;
                if (na < ADDR_W) bits_a[na] = mwdata;
                else if (na - ADDR_W < DATA_W) bits_d[na - ADDR_W] = mwdata;
                na++;
                if (na == ADDR_W) w_obs = t + 1;
            end
            if (!ended) begin
                if (breq !== 1'b1) breq_bad++;
                if (mmode !== mode) mmode_bad++;
            end

            dvalid = hold_dv && !ended;
            dmode  = 1'($urandom);
            daddr  = ADDR_W'($urandom);
            dwdata = DATA_W'($urandom);
            bgrant = !ended && (t >= 1 + g) && !(drop >= 0 && ack_t >= 0 && t >= ack_t + 1 + drop);
            ack    = !ended && (w_obs >= 0) && (ack_t < 0) && (t == w_obs + k);
            if (ack) ack_t = t;
            svalid = 1'b0;
            mrdata = 1'($urandom);
            if (!ended && !mode && ack_t >= 0 && t > ack_t) begin
                rel = t - (ack_t + 1) - gap;
                if (rel >= 0 && rel % (gap + 1) == 0 && rel / (gap + 1) < DATA_W) begin
                    svalid = 1'b1;
                    mrdata = rd[rel / (gap + 1)];
                end
            end
        end

        check({name, ".end_cycle"}, end_t, exp_end);
        check({name, ".ddone"}, 32'(ddone), 32'(exp_ok));
        check({name, ".dfail"}, 32'(dfail), 32'(!exp_ok));
        check({name, ".dready"}, 32'(dready), 32'd1);
        check({name, ".breq_low"}, 32'(breq), 32'd0);
        check({name, ".mvalid_low"}, 32'(mvalid), 32'd0);
        check({name, ".breq_hold"}, breq_bad, 0);
        check({name, ".mmode"}, mmode_bad, 0);
        check({name, ".first_mvalid"}, first_mv, a0);
        if (exp_ok) begin
            check({name, ".addr_bits"}, 32'(bits_a), 32'(addr));
            check({name, ".nbits"}, na, mode ? ADDR_W + DATA_W : ADDR_W);
            if (mode) check({name, ".data_bits"}, 32'(bits_d), 32'(wd));
            else exp_drdata = rd;
        end
        check({name, ".drdata"}, 32'(drdata), 32'(exp_drdata));

        dvalid = 1'b0; bgrant = 1'b0; ack = 1'b0; svalid = 1'b0;
        tick();
        check({name, ".pulse_width"}, 32'({ddone, dfail}), 32'd0);
        check({name, ".idle_breq"}, 32'(breq), 32'd0);
        check({name, ".drdata_hold"}, 32'(drdata), 32'(exp_drdata));
    endtask

    initial begin
        int n, t, bad, gap, g, k, drop, len;
        logic mode;

        rstn = 1'b0; dvalid = 1'b0; dmode = 1'b0; daddr = '0; dwdata = '0;
        bgrant = 1'b0; ack = 1'b0; mrdata = 1'b0; svalid = 1'b0;
        tick();
        tick();
        check("reset.dready", 32'(dready), 32'd1);
        check("reset.breq", 32'(breq), 32'd0);
        check("reset.mvalid", 32'(mvalid), 32'd0);
        check("reset.mwdata", 32'(mwdata), 32'd0);
        check("reset.mmode", 32'(mmode), 32'd0);
        check("reset.pulses", 32'({ddone, dfail}), 32'd0);
        check("reset.drdata", 32'(drdata), 32'd0);
        rstn = 1'b1;
        tick();

        xfer("t1_write",   1'b1, 14'h0123, 8'hA5, 8'h00, 1, 0, 0, -1, 1'b0);
        xfer("t2_read",    1'b0, 14'h0040, 8'h00, 8'h3C, 1, 2, 2, -1, 1'b0);
        xfer("t3_stale",   1'b1, 14'h1555, 8'h81, 8'h00, -1, 0, 0, -1, 1'b0);
        xfer("t4_timeout", 1'b0, 14'h0200, 8'h00, 8'hFF, 1, ACK_TO, 0, -1, 1'b0);
        xfer("ack_last",   1'b0, 14'h3FFF, 8'h00, 8'hC3, 2, ACK_TO - 1, 0, -1, 1'b0);
        xfer("t5_drop",    1'b1, 14'h0ABC, 8'h5A, 8'h00, 1, 1, 0, 3, 1'b0);
        xfer("t5_after",   1'b1, 14'h0001, 8'h7E, 8'h00, 0, 0, 0, -1, 1'b0);

        // Reset in the middle of the address phase.
        dvalid = 1'b1; dmode = 1'b1; daddr = 14'h2AAA; dwdata = 8'h5A; bgrant = 1'b1;
        n = 0; t = 0;
        while (n < 3 && t < 50) begin
            tick();
            t++;
            dvalid = 1'b0;
            if (mvalid) n++;
        end
        check("t6.reached_addr", n, 3);
        rstn = 1'b0;
        tick();
        check("t6.dready", 32'(dready), 32'd1);
        check("t6.breq", 32'(breq), 32'd0);
        check("t6.mvalid", 32'(mvalid), 32'd0);
        check("t6.mwdata", 32'(mwdata), 32'd0);
        check("t6.mmode", 32'(mmode), 32'd0);
        check("t6.pulses", 32'({ddone, dfail}), 32'd0);
        check("t6.drdata", 32'(drdata), 32'd0);
        exp_drdata = '0;
        rstn = 1'b1; bgrant = 1'b0;
        bad = 0;
        repeat (4) begin
            tick();
            if (ddone || dfail || breq) bad++;
        end
        check("t6.quiet", bad, 0);

        xfer("t6_hold_dv", 1'b0, 14'h0F0F, 8'h00, 8'h96, 1, 3, 1, -1, 1'b1);

        for (int i = 0; i < 24; i++) begin
            mode = 1'($urandom);
            g    = $urandom_range(0, 4) - 1;
            gap  = $urandom_range(0, 2);
            k    = ($urandom_range(0, 3) == 0) ? ACK_TO + $urandom_range(0, 1) : $urandom_range(0, ACK_TO - 1);
            len  = mode ? DATA_W : DATA_W * (gap + 1);
            drop = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len - 1) : -1;
            xfer($sformatf("rnd%0d", i), mode, ADDR_W'($urandom), DATA_W'($urandom), DATA_W'($urandom),
                 g, k, gap, drop, 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
